// File: rtl/pdm_capture_seq.sv
// pdm_capture_seq: counts PDM bit strobes into words and writes them, channel-interleaved, to capture memory
module pdm_capture_seq #(
    parameter int BITS_PER_WORD = 32,
    parameter int DEPTH         = 46875,
    parameter int NUM_CH        = 2,
    parameter int ADDR_W        = 17,
    parameter int CH_W          = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode_cont,
    input  logic              bit_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CH_W-1:0]   wr_ch,
    output logic [ADDR_W-1:0] word_idx,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic              overrun
);

    localparam int BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam logic [BW-1:0]     BIT_LAST  = BW'(BITS_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, DONE} state_t;

    state_t            state, state_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [ADDR_W-1:0] word_idx_n;
    logic [CH_W-1:0]   wr_ch_n;
    logic              mode, mode_n, overrun_n, done_n;
    logic              word_end, last_wr, last_word;

    assign word_end  = bit_en && bit_cnt == BIT_LAST;
    assign last_wr   = state == WRITE && wr_ch == CH_LAST;
    assign last_word = word_idx == WORD_LAST;

    assign wr_en   = state == WRITE;
    assign busy    = state == CAPTURE || state == WRITE;
    assign wrap    = last_wr && last_word && mode;
    assign wr_addr = word_idx * ADDR_W'(NUM_CH) + ADDR_W'(wr_ch);

    // state, counters, mode latch and sticky/pulse flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            word_idx <= '0;
            wr_ch    <= '0;
            mode     <= 1'b0;
            overrun  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            word_idx <= word_idx_n;
            wr_ch    <= wr_ch_n;
            mode     <= mode_n;
            overrun  <= overrun_n;
            done     <= done_n;
        end
    end

    // next state; abort on en low overrides everything, including a same-cycle strobe
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        word_idx_n = word_idx;
        wr_ch_n    = wr_ch;
        mode_n     = mode;
        overrun_n  = overrun;
        done_n     = 1'b0;
        if (!en) begin
            state_n    = IDLE;
            bit_cnt_n  = '0;
            word_idx_n = '0;
            wr_ch_n    = '0;
            overrun_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = CAPTURE;
                    mode_n  = mode_cont;
                end
                CAPTURE: begin
                    if (bit_en) bit_cnt_n = word_end ? '0 : bit_cnt + 1'b1;
                    if (word_end) begin
                        state_n = WRITE;
                        wr_ch_n = '0;
                    end
                end
                WRITE: begin
                    // strobes keep counting; a word finishing here has nowhere to go and is dropped
                    if (bit_en) bit_cnt_n = word_end ? '0 : bit_cnt + 1'b1;
                    if (word_end) overrun_n = 1'b1;
                    if (last_wr) begin
                        wr_ch_n = '0;
                        if (!last_word) begin
                            word_idx_n = word_idx + 1'b1;
                            state_n    = CAPTURE;
                        end else if (mode) begin
                            word_idx_n = '0;
                            state_n    = CAPTURE;
                        end else begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        wr_ch_n = wr_ch + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_capture_seq.sv
// tb_pdm_capture_seq: cycle vector table plus scoreboarded frame, abort and async-reset sequences
module tb_pdm_capture_seq;

    localparam int ADDR_W = 4;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst, en, mode_cont, bit_en;
    logic              wr_en, busy, done, wrap, overrun;
    logic [ADDR_W-1:0] wr_addr, word_idx;
    logic [CH_W-1:0]   wr_ch;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic sb_on = 1'b0;
    int sb_q[$];

    typedef struct packed {
        logic       en, b, m;
        logic       we;
        logic [3:0] addr;
        logic       busy, done, wrap, ovr;
    } vec_t;

    vec_t tbl[23];

    pdm_capture_seq #(
        .BITS_PER_WORD(2), .DEPTH(3), .NUM_CH(2), .ADDR_W(ADDR_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode_cont(mode_cont), .bit_en(bit_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_ch(wr_ch), .word_idx(word_idx),
        .busy(busy), .done(done), .wrap(wrap), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic we, input int addr,
                           input logic bsy, input logic dn, input logic wp, input logic ov);
        chk({tag, "_wr_en"}, int'(wr_en), int'(we));
        chk({tag, "_addr"}, int'(wr_addr), addr);
        chk({tag, "_busy"}, int'(busy), int'(bsy));
        chk({tag, "_done"}, int'(done), int'(dn));
        chk({tag, "_wrap"}, int'(wrap), int'(wp));
        chk({tag, "_overrun"}, int'(overrun), int'(ov));
    endtask

    task automatic step(input logic e, input logic b);
        @(negedge clk);
        en = e;
        bit_en = b;
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1);
            repeat (3) step(1'b1, 1'b0);
        end
    endtask

    function automatic vec_t v(input logic e, b, m, we, input logic [3:0] a,
                               input logic bs, dn, wp, ov);
        vec_t r;
        r = '{en: e, b: b, m: m, we: we, addr: a, busy: bs, done: dn, wrap: wp, ovr: ov};
        return r;
    endfunction

    // scoreboard: every write must match the next queued address; done pulses are counted
    always @(negedge clk) begin
        if (sb_on) begin
            if (wr_en) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected_write: got addr %0d expected no write at %0t", wr_addr, $time);
                end else begin
                    int e;
                    e = sb_q.pop_front();
                    chk("sb_addr", int'(wr_addr), e);
                    chk("sb_ch", int'(wr_ch), e % 2);
                end
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // continuous run (mode change mid-capture ignored), abort mid-write, then overrun
        tbl[0]  = v(1,0,1, 0,0,1,0,0,0);
        tbl[1]  = v(1,1,1, 0,0,1,0,0,0);
        tbl[2]  = v(1,1,1, 1,0,1,0,0,0);
        tbl[3]  = v(1,0,1, 1,1,1,0,0,0);
        tbl[4]  = v(1,0,1, 0,2,1,0,0,0);
        tbl[5]  = v(1,1,1, 0,2,1,0,0,0);
        tbl[6]  = v(1,1,1, 1,2,1,0,0,0);
        tbl[7]  = v(1,0,1, 1,3,1,0,0,0);
        tbl[8]  = v(1,1,0, 0,4,1,0,0,0);
        tbl[9]  = v(1,1,0, 1,4,1,0,0,0);
        tbl[10] = v(1,0,0, 1,5,1,0,1,0);
        tbl[11] = v(1,0,0, 0,0,1,0,0,0);
        tbl[12] = v(1,1,0, 0,0,1,0,0,0);
        tbl[13] = v(1,1,0, 1,0,1,0,0,0);
        tbl[14] = v(0,0,0, 0,0,0,0,0,0);
        tbl[15] = v(1,0,0, 0,0,1,0,0,0);
        tbl[16] = v(1,1,0, 0,0,1,0,0,0);
        tbl[17] = v(1,1,0, 1,0,1,0,0,0);
        tbl[18] = v(1,1,0, 1,1,1,0,0,0);
        tbl[19] = v(1,1,0, 0,2,1,0,0,1);
        tbl[20] = v(1,1,0, 0,2,1,0,0,1);
        tbl[21] = v(1,1,0, 1,2,1,0,0,1);
        tbl[22] = v(0,0,0, 0,0,0,0,0,0);

        rst = 1'b0;
        en = 1'b0;
        bit_en = 1'b0;
        mode_cont = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        chk("reset_word_idx", int'(word_idx), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            en = tbl[i].en;
            bit_en = tbl[i].b;
            mode_cont = tbl[i].m;
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), tbl[i].we, int'(tbl[i].addr),
                    tbl[i].busy, tbl[i].done, tbl[i].wrap, tbl[i].ovr);
        end

        // single-shot frame of 3 words, then DONE held with en high
        sb_on = 1'b1;
        mode_cont = 1'b0;
        for (int a = 0; a < 6; a++) sb_q.push_back(a);
        step(1'b1, 1'b0);
        strobes(6);
        chk("frame_done_cnt", done_cnt, 1);
        chk("frame_busy", int'(busy), 0);
        chk("frame_word_idx", int'(word_idx), 2);
        for (int i = 0; i < 100; i++) step(1'b1, 1'(i % 3 == 0));
        chk("hold_done_cnt", done_cnt, 1);
        chk("hold_busy", int'(busy), 0);
        chk("hold_queue", sb_q.size(), 0);

        // drop en, re-enable: new frame from address 0
        step(1'b0, 1'b0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_word_idx", int'(word_idx), 0);
        sb_q.push_back(0);
        sb_q.push_back(1);
        step(1'b1, 1'b0);
        strobes(2);
        chk("restart_queue", sb_q.size(), 0);
        chk("restart_word_idx", int'(word_idx), 1);
        step(1'b0, 1'b0);
        sb_on = 1'b0;

        // async reset between edges mid-capture, with one strobe already counted
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("rst_cnt_cleared_wr_en", int'(wr_en), 0);
        step(1'b1, 1'b1);
        chk_out("rst_first_word", 1, 0, 1, 0, 0, 0);
        step(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
